radix_2_ntt_scheduler: RTL
==========================

# radix_2_ntt_scheduler

Sequencing controller for the radix-2 NTT butterfly datapath, i.e. the add/subtract adder pair plus modular multiplier. It walks all LOGN stages of an in-place N = 2^LOGN point decimation-in-frequency transform. For each butterfly it issues one read-address pair and the matching twiddle index. It also delays those addresses through a fixed-latency write-back pipeline, so results land in the same locations. Between stages it drains the pipeline, which keeps every read from seeing stale data.

## Interface
- LOGN, default 8: log2 of transform size. Must be ≥ 2.
- PIPE_LAT, default 3: datapath latency in cycles, from read issue to write-back. Must be ≥ 1.
- clk, input, 1: the single clock.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a transform. Sampled only in IDLE.
- stall, input, 1: suppresses butterfly issue while high in RUN.
- busy, output, 1: high while in RUN or FLUSH.
- done, output, 1: one-cycle pulse when the transform is complete.
- rd_valid, output, 1: a butterfly is issued this cycle.
- rd_addr_a, output, LOGN: upper-leg read address.
- rd_addr_b, output, LOGN: lower-leg read address.
- tw_addr, output, LOGN-1: twiddle ROM index.
- stage, output, $clog2(LOGN): index of the current stage.
- wr_valid, output, 1: write-back strobe, equal to rd_valid delayed by PIPE_LAT.
- wr_addr_a, output, LOGN: rd_addr_a delayed by PIPE_LAT.
- wr_addr_b, output, LOGN: rd_addr_b delayed by PIPE_LAT.

## Operation
- States are IDLE, RUN, FLUSH and DONE.
- Counters:
  - stage s runs from 0 to LOGN-1.
  - butterfly j runs from 0 to N/2-1.
  - flush counter f runs from 0 to PIPE_LAT-1.
- Address arithmetic for stage s:
  - m = N >> (s+1), g = j / m, k = j mod m.
  - rd_addr_a = 2·m·g + k, rd_addr_b = rd_addr_a + m.
  - tw_addr = k << s, truncated to LOGN-1 bits.
  - All of this is shift/mask logic; no dividers.
- IDLE:
  - If start = 1, go to RUN with s = 0 and j = 0.
  - Otherwise stay in IDLE.
- RUN:
  - rd_valid = !stall.
  - A cycle with rd_valid = 1 issues butterfly (s, j) and increments j.
  - A stalled cycle holds all counters, and the address outputs keep their values.
  - When j = N/2-1 is issued, go to FLUSH with f = 0.
- FLUSH:
  - rd_valid = 0, and stall is ignored.
  - f increments every cycle.
  - At f = PIPE_LAT-1:
    - If s < LOGN-1, increment s, set j = 0 and go to RUN.
    - If s = LOGN-1, go to DONE.
- DONE lasts one cycle: done = 1 and busy = 0. The next state is IDLE.
- start is ignored in RUN, FLUSH and DONE. There is no queuing.
- The write pipeline:
  - It is a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}.
  - It advances every cycle unconditionally, and is independent of stall.
- wr_addr_a and wr_addr_b are 0 whenever wr_valid = 0 (zero-masked).

## Timing
- Reset (rst_n = 0, asynchronous):
  - State goes to IDLE.
  - All counters go to 0.
  - All outputs go to 0, including every delay-line stage.
- Reset mid-transform aborts immediately. No done pulse is produced and in-flight writes are discarded.
- Handshake timing:
  - start is sampled high at edge t. At t+1 the block is in RUN with busy = 1, and rd_valid = 1 with butterfly (0, 0) unless stall is high.
  - A read issued in cycle c produces wr_valid in cycle c+PIPE_LAT.
  - The last write of a stage occurs in the final FLUSH cycle.
  - The first read of the next stage is issued in the following cycle, so reads never overtake pending writes.
- Stall-free transform time:
  - busy stays high for LOGN·(N/2 + PIPE_LAT) cycles.
  - done pulses in the cycle after busy falls.
  - Each stall cycle in RUN adds exactly one cycle.
- stall asserted in the same cycle as the last issue of a stage delays that issue. FLUSH starts only after the issue actually happens.
- wr_valid is never high in IDLE or DONE, except after a reset abort, where it is already cleared.

## Test plan
- Setup for the directed cases is LOGN = 3 and PIPE_LAT = 2. Pulse start for one cycle, with no stall.
  - Stage 0 issues (a, b, tw) = (0,4,0), (1,5,1), (2,6,2), (3,7,3).
  - Stage 1 issues (0,2,0), (1,3,2), (4,6,0), (5,7,2).
  - Stage 2 issues (0,1,0), (2,3,0), (4,5,0), (6,7,0).
  - busy is high for exactly 18 cycles, and done pulses once in cycle 19 after the start edge.
- Write-back and drain check:
  - Each wr_valid/wr_addr equals its rd counterpart exactly 2 cycles later.
  - rd_valid is low for 2 cycles between stages.
  - No read in stage s+1 is issued before the last stage-s write.
- Stall check:
  - Assert stall for 3 cycles during stage 1, after j = 1.
  - Address outputs hold their values, issue resumes at (4,6,0), and total busy time is 21 cycles.
  - Stall asserted during FLUSH has no effect on timing.
- start re-pulsed during RUN and during DONE:
  - It is ignored; exactly one done pulse results.
  - A start in the IDLE cycle after DONE launches a new transform.
- rst_n pulled low mid-stage 1 with writes in flight:
  - All outputs are 0 immediately (asynchronously), and no done pulse appears.
  - After release plus a start, the full 18-cycle sequence repeats correctly.
- Larger configuration, LOGN = 8 and PIPE_LAT = 3, with random stall:
  - A scoreboard checks that every address 0..255 is written exactly once per stage.
  - The pairs satisfy b − a = 256 >> (s+1).
  - tw_addr stays within 0..127.

Source files
------------

// File: rtl/radix_2_ntt_scheduler.sv
// Sequencer for an in-place radix-2 DIF NTT: issues butterfly read pairs and twiddle indices
// stage by stage, and delays the read addresses through a fixed-latency write-back line.
module radix_2_ntt_scheduler #(
    parameter int LOGN     = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stall,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_valid,
    output logic [LOGN-1:0]            rd_addr_a,
    output logic [LOGN-1:0]            rd_addr_b,
    output logic [LOGN-2:0]            tw_addr,
    output logic [$clog2(LOGN)-1:0]    stage,
    output logic                       wr_valid,
    output logic [LOGN-1:0]            wr_addr_a,
    output logic [LOGN-1:0]            wr_addr_b
);

    localparam int SW = $clog2(LOGN);
    localparam int JW = LOGN - 1;
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [JW-1:0] J_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
    localparam logic [FW-1:0] F_LAST = FW'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [JW-1:0]   j_q, j_d;
    logic [FW-1:0]   f_q, f_d;

    logic [PIPE_LAT-1:0]           pv_q, pv_d;
    logic [PIPE_LAT-1:0][LOGN-1:0] pa_q, pa_d;
    logic [PIPE_LAT-1:0][LOGN-1:0] pb_q, pb_d;

    logic [JW-1:0]   k_mask;
    logic [JW-1:0]   k_val;
    logic [JW-1:0]   g_bits;
    logic [LOGN-1:0] addr_a;
    logic [LOGN-1:0] addr_b;
    logic [JW-1:0]   tw_val;
    logic            in_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            f_q     <= '0;
            pv_q    <= '0;
            pa_q    <= '0;
            pb_q    <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            f_q     <= f_d;
            pv_q    <= pv_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        f_d     = f_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (j_q == J_LAST) begin
                        state_d = FLUSH;
                        f_d     = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (f_q == F_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        s_d     = s_q + 1'b1;
                        j_d     = '0;
                    end
                end else begin
                    f_d = f_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
                j_d     = '0;
                f_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // k_mask = m-1 with m = N >> (s+1); the low bits of j give k, the high bits give 2*m*g once shifted up
    always_comb begin
        k_mask = {JW{1'b1}} >> s_q;
        k_val  = j_q & k_mask;
        g_bits = j_q & ~k_mask;
        addr_a = {g_bits, 1'b0} | {1'b0, k_val};
        addr_b = addr_a + {1'b0, k_mask} + LOGN'(1);
        tw_val = k_val << s_q;
    end

    always_comb begin
        in_run    = (state_q == RUN);
        busy      = (state_q == RUN) || (state_q == FLUSH);
        done      = (state_q == DONE);
        rd_valid  = in_run && !stall;
        rd_addr_a = in_run ? addr_a : '0;
        rd_addr_b = in_run ? addr_b : '0;
        tw_addr   = in_run ? tw_val : '0;
        stage     = s_q;
    end

    // The write-back line shifts every cycle regardless of stall; bubbles carry zeroed addresses
    always_comb begin
        pv_d    = '0;
        pa_d    = '0;
        pb_d    = '0;
        pv_d[0] = rd_valid;
        pa_d[0] = rd_valid ? addr_a : '0;
        pb_d[0] = rd_valid ? addr_b : '0;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pa_d[i] = pa_q[i-1];
            pb_d[i] = pb_q[i-1];
        end
    end

    always_comb begin
        wr_valid  = pv_q[PIPE_LAT-1];
        wr_addr_a = pv_q[PIPE_LAT-1] ? pa_q[PIPE_LAT-1] : '0;
        wr_addr_b = pv_q[PIPE_LAT-1] ? pb_q[PIPE_LAT-1] : '0;
    end

endmodule
